// File: rtl/conv_window_reduce_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared geometry, widths and types for conv_window_reduce and its adder-tree
// levels. The window is K_DIM x K_DIM signed products. Each sum is widened by
// clog2(N) bits, which is enough that the sum of N products can never overflow.
// -----------------------------------------------------------------------------
package conv_pkg;

  localparam int K_DIM  = 3;
  localparam int M_BITS = 16;
  localparam int I_BITS = 16;

  localparam int N      = K_DIM * K_DIM;   // products per window
  localparam int D      = $clog2(N);       // adder-tree depth
  localparam int S_BITS = M_BITS + D;      // overflow-free sum width
  localparam int P      = D + 1;           // register stages, input to output

  typedef logic signed [M_BITS-1:0]        prod_t;
  typedef prod_t [K_DIM-1:0][K_DIM-1:0]    window_t;  // element [r][c]
  typedef logic [1:0][I_BITS-1:0]          coord_t;   // [1]=row, [0]=col
  typedef logic signed [S_BITS-1:0]        sum_t;

  // Number of partial sums held after `level` pairwise reductions.
  // An odd leftover passes through a level unchanged, hence the round-up.
  function automatic int level_count(input int level);
    int n;
    n = N;
    for (int i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

endpackage

// File: rtl/conv_window_reduce_if.sv
// -----------------------------------------------------------------------------
// AXI4-Stream style bundles for conv_window_reduce.
//   conv_mult_if : window of products in  (data, valid, ready, last, user)
//   conv_out_if  : window sum out         (data, valid, ready, last, user)
// master drives data/valid/last/user and samples ready; slave is the mirror.
// -----------------------------------------------------------------------------
interface conv_mult_if;
  import conv_pkg::*;

  window_t data;
  logic    valid;
  logic    ready;
  logic    last;
  coord_t  user;

  modport master (output data, valid, last, user, input  ready);
  modport slave  (input  data, valid, last, user, output ready);
endinterface

interface conv_out_if;
  import conv_pkg::*;

  sum_t    data;
  logic    valid;
  logic    ready;
  logic    last;
  coord_t  user;

  modport master (output data, valid, last, user, input  ready);
  modport slave  (input  data, valid, last, user, output ready);
endinterface

// File: rtl/conv_window_reduce_tree.sv
// -----------------------------------------------------------------------------
// adder_tree_level
// One registered level of the pairwise adder tree with valid/ready flow
// control. Output i is in[2i] + in[2i+1]; an odd last input passes through.
// When RELU is set, negative results are clamped to zero before the register
// (used only on the final level so the clamp adds no stage).
//
// Ports
//   clk, aresetn          clock, synchronous active-low reset
//   in_data/valid/user/last, in_ready     upstream side
//   out_data/valid/user/last, out_ready   downstream side
// -----------------------------------------------------------------------------
module adder_tree_level
  import conv_pkg::*;
#(
  parameter int IN_CNT  = 2,
  parameter int OUT_CNT = (IN_CNT + 1) / 2,
  parameter bit RELU    = 1'b0
) (
  input  logic                clk,
  input  logic                aresetn,

  input  sum_t [IN_CNT-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  coord_t              in_user,
  input  logic                in_last,

  output sum_t [OUT_CNT-1:0]  out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output coord_t              out_user,
  output logic                out_last
);

  sum_t [OUT_CNT-1:0] level_sum;

  for (genvar i = 0; i < OUT_CNT; i++) begin : g_pair
    sum_t pair_sum;

    if (2 * i + 1 < IN_CNT) begin : g_add
      assign pair_sum = in_data[2*i] + in_data[2*i+1];
    end else begin : g_pass
      assign pair_sum = in_data[2*i];
    end

    assign level_sum[i] = (RELU && (pair_sum < 0)) ? '0 : pair_sum;
  end

  // This level may load whenever its register is empty or being drained.
  assign in_ready = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
    end
  end

  // NOTE: payload registers are deliberately not reset; valid alone qualifies
  // them, and leaving them reset-free keeps the wide datapath cheap.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      out_data <= level_sum;
      out_user <= in_user;
      out_last <= in_last;
    end
  end

endmodule

// File: rtl/conv_window_reduce.sv
// -----------------------------------------------------------------------------
// conv_window_reduce
// Consumes a stream of K_DIM x K_DIM windows of signed products and emits one
// signed window sum per beat. Stage 0 registers the beat sign-extended to
// S_BITS; D registered adder-tree levels reduce it to a single sum; the last
// level drives the output stream (optionally ReLU-clamped). user and last ride
// alongside each sum unchanged. Every stage holds one beat, so the block
// absorbs P beats under sustained backpressure.
//
// Ports
//   clk         clock
//   aresetn     synchronous active-low reset
//   mult        window input stream (slave)
//   out         window sum output stream (master)
//   frame_done  one-cycle pulse the cycle after a last beat leaves the block
// -----------------------------------------------------------------------------
module conv_window_reduce
  import conv_pkg::*;
#(
  parameter bit RELU_EN = 1'b0
) (
  input  logic        clk,
  input  logic        aresetn,
  conv_mult_if.slave  mult,
  conv_out_if.master  out,
  output logic        frame_done
);

  // ---------------------------------------------------------------- stage 0
  sum_t [N-1:0] s0_ext;
  sum_t [N-1:0] s0_data;
  logic         s0_valid;
  logic         s0_ready;
  coord_t       s0_user;
  logic         s0_last;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    s0_ext = '0;
    for (int r = 0; r < K_DIM; r++) begin
      for (int c = 0; c < K_DIM; c++) begin
        s0_ext[r*K_DIM + c] = sum_t'(mult.data[r][c]);
      end
    end
  end

  // ------------------------------------------------------- adder-tree levels
  for (genvar l = 0; l < D; l++) begin : g_lvl
    localparam int IN_CNT  = level_count(l);
    localparam int OUT_CNT = level_count(l + 1);

    sum_t [IN_CNT-1:0]  in_data;
    logic               in_valid;
    logic               in_ready;
    coord_t             in_user;
    logic               in_last;

    sum_t [OUT_CNT-1:0] lv_data;
    logic               lv_valid;
    logic               lv_ready;
    coord_t             lv_user;
    logic               lv_last;

    if (l == 0) begin : g_head
      assign in_data  = s0_data;
      assign in_valid = s0_valid;
      assign in_user  = s0_user;
      assign in_last  = s0_last;
    end else begin : g_link
      assign in_data  = g_lvl[l-1].lv_data;
      assign in_valid = g_lvl[l-1].lv_valid;
      assign in_user  = g_lvl[l-1].lv_user;
      assign in_last  = g_lvl[l-1].lv_last;
    end

    if (l == D - 1) begin : g_tail
      assign lv_ready = out.ready;
    end else begin : g_mid
      assign lv_ready = g_lvl[l+1].in_ready;
    end

    adder_tree_level #(
      .IN_CNT  (IN_CNT),
      .OUT_CNT (OUT_CNT),
      .RELU    ((l == D - 1) ? RELU_EN : 1'b0)
    ) u_level (
      .clk       (clk),
      .aresetn   (aresetn),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_user   (in_user),
      .in_last   (in_last),
      .out_data  (lv_data),
      .out_valid (lv_valid),
      .out_ready (lv_ready),
      .out_user  (lv_user),
      .out_last  (lv_last)
    );
  end

  // Ready ripples combinationally from out.ready back to mult.ready.
  assign s0_ready   = !s0_valid || g_lvl[0].in_ready;
  assign mult.ready = s0_ready;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      s0_valid <= 1'b0;
    end else if (s0_ready) begin
      s0_valid <= mult.valid;
    end
  end

  always_ff @(posedge clk) begin
    if (s0_ready && mult.valid) begin
      s0_data <= s0_ext;
      s0_user <= mult.user;
      s0_last <= mult.last;
    end
  end

  // ----------------------------------------------------------------- output
  sum_t   res_data;
  logic   res_valid;
  coord_t res_user;
  logic   res_last;
  logic   out_fire;

  assign res_data  = g_lvl[D-1].lv_data[0];
  assign res_valid = g_lvl[D-1].lv_valid;
  assign res_user  = g_lvl[D-1].lv_user;
  assign res_last  = g_lvl[D-1].lv_last;

  assign out.data  = res_data;
  assign out.valid = res_valid;
  assign out.user  = res_user;
  assign out.last  = res_last;
  assign out_fire  = res_valid && out.ready;

  // Output beats seen in the current frame; observed only by assertions.
  logic [31:0] beat_cnt;

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      frame_done <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      frame_done <= out_fire && res_last;
      if (out_fire) begin
        beat_cnt <= res_last ? '0 : beat_cnt + 32'd1;
      end
    end
  end

  // A stalled output beat must stay put until it is taken.
  a_out_stable : assert property (@(posedge clk) disable iff (!aresetn)
    (res_valid && !out.ready) |=>
      (res_valid && $stable(res_data) && $stable(res_user) && $stable(res_last)));

  // The frame counter restarts on the same edge that raises frame_done.
  a_frame_restart : assert property (@(posedge clk) disable iff (!aresetn)
    frame_done |-> (beat_cnt == '0));

endmodule

// File: doc/conv_window_reduce.md
Name: conv_window_reduce

Overview:
- AXI4-Stream consumer of the wrapper's multiply stream (mult_*).
- Each accepted beat carries a K_DIM x K_DIM window of signed element-wise products.
- The block sums each window through a registered, pipelined adder tree, optionally applies ReLU, and emits one convolution output per beat.
- mult_user (pixel coordinates) and mult_last travel alongside each sum unchanged.

Parameters:
- K_DIM, 3, kernel edge length; window holds N = K_DIM*K_DIM products.
- M_BITS, 16, signed width of each product element.
- I_BITS, 16, width of each coordinate in user.
- RELU_EN, 0, when 1, negative sums are output as 0.

Ports:
- clk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low
- mult_data  in  [K_DIM][K_DIM][M_BITS]  signed products, element [r][c]
- mult_valid  in  1  AXIS tvalid
- mult_ready  out  1  AXIS tready
- mult_last  in  1  last window of frame
- mult_user  in  [2][I_BITS]  {row, col} of window centre
- out_data  out  S_BITS = M_BITS+clog2(N)  signed window sum
- out_valid  out  1  AXIS tvalid
- out_ready  in  1  AXIS tready
- out_last  out  1  passthrough of mult_last
- out_user  out  [2][I_BITS]  passthrough of mult_user
- frame_done  out  1  one-cycle pulse when a beat with out_last=1 is accepted downstream

Behaviour:
- Reset: only the sampled aresetn=0 edge has effect. Clears every stage valid bit, out_valid=0, frame_done=0, and the beat counter. Data/user/last registers are don't-care.
- Reset mid-operation: all in-flight beats are discarded; no partial output after reset release.
- Pipeline structure: P = D+1 register stages, where D = clog2(N); 4 for K_DIM=3, so P=5.
  - Stage 0 registers the input beat, sign-extended to S_BITS.
  - Stages 1..D are pairwise adder-tree levels; odd leftovers pass through that level unchanged.
  - The final stage drives out_*.
- Latency: beat accepted at edge t gives out_valid=1 after edge t+P-1 (visible in cycle t+P-1 with no backpressure; a beat accepted in cycle 0 is presented in cycle 4).
- Throughput: one beat per cycle while out_ready=1.
- Handshake: every stage carries valid plus user/last.
  - Stage k advances when its successor is empty or advancing: ready_k = !valid_{k+1} | ready_{k+1}.
  - mult_ready = ready_0; out_valid = last-stage valid.
  - The combinational ready chain from out_ready to mult_ready is permitted.
- Capacity: under sustained out_ready=0 the block absorbs exactly P beats, then drops mult_ready. No beat is lost, duplicated or reordered.
- AXIS rules:
  - out_data/out_user/out_last stay stable while out_valid=1 and out_ready=0.
  - out_valid never depends combinationally on out_ready.
- Arithmetic: exact two's-complement; S_BITS guarantees no overflow for any input. With RELU_EN=1 the ReLU is applied at the final stage (sum<0 -> 0), without adding a stage.
- frame_done: registered, asserted the cycle after out_valid & out_ready & out_last.
- Beat counter: internal 32-bit count of output beats in the current frame. Cleared after a last beat or by reset; exposed only for assertions.
- Simultaneous accept on input and output in one cycle is legal and keeps occupancy constant.

Decomposition:
- Shared package `conv_pkg` holds:
  - K_DIM, M_BITS, I_BITS;
  - clog2-derived S_BITS and tree depth D;
  - typedefs for window_t [K_DIM][K_DIM][M_BITS], coord_t [2][I_BITS], sum_t.
- One natural sub-module, `adder_tree_level`: one registered pairwise-add level with valid/ready. It is instantiated D times via generate.

Test Plan:
- All 9 products = 1, user={5,7}, last=0, out_ready=1 -> out_data=9, out_user={5,7}, out_valid 4 cycles after acceptance.
- All products 16'h7FFF -> out_data=294903; all 16'h8000 -> -294912 (20-bit). RELU_EN=1 with all -1 -> 0.
- out_ready=0 for 12 cycles while 8 beats offered -> exactly 5 accepted, mult_ready=0. Release -> 8 outputs in order, values intact, stable while stalled.
- Frame of 4 beats, last on 4th -> out_last only on 4th output, frame_done pulses once the cycle after its acceptance.
- aresetn=0 for 1 cycle with 3 beats in flight -> out_valid=0 next cycle, no stale outputs afterward, the next beat has latency 4.
- Random valid/ready toggling, 1000 beats -> scoreboard matches reference sum, user and last per beat; zero AXIS stability violations.
